// File: rtl/rib_sram_slave_if.sv
// Request/response bus between the core (RIB master) and the SRAM slave.
// Signal names keep the master-facing _i/_o suffixes seen from the slave.
interface rib_sram_slave_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        hold_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  hold_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output hold_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/rib_sram_slave.sv
// Single-port SRAM slave with a 2-entry posted write buffer and 1-cycle reads.
// Optional macro RIB_SRAM_FWD_EN: forward buffered write data to hazard reads instead of stalling.
module rib_sram_slave #(
  parameter int unsigned DEPTH = 1024
) (
  input logic              clk,
  input logic              rst_n,
  rib_sram_slave_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] idx_t;
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e      state_q, state_d;
  idx_t        idx0_q, idx0_d, idx1_q, idx1_d;
  logic [31:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic [31:0] mem [DEPTH];

  idx_t        req_idx;
  logic        rd_req, wr_req;
  logic        match0, match1, hazard;
  logic        hold;
  logic        rd_acc, wr_acc, drain;
  logic [31:0] rd_word;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        unused_addr;

  // Byte offset and bits above the word index alias freely.
  assign req_idx     = bus.addr_i[AW+1:2];
  assign unused_addr = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};

  assign rd_req = bus.req_i & ~bus.we_i;
  assign wr_req = bus.req_i & bus.we_i;

  // entry0 is always the oldest; entry1 is only live when full.
  assign match0 = (state_q != StEmpty) && (idx0_q == req_idx);
  assign match1 = (state_q == StFull) && (idx1_q == req_idx);
  assign hazard = rd_req & (match0 | match1);

  // In reset the buffer is seen as already empty, so nothing stalls.
  always_comb begin
    hold = 1'b0;
    if (!rst_n) begin
      if (wr_req && state_q == StFull) hold = 1'b1;
`ifndef RIB_SRAM_FWD_EN
      if (hazard) hold = 1'b1;
`endif
    end
  end

  assign bus.hold_o = hold;

  assign rd_acc = rd_req & ~hold & ~rst_n;
  assign wr_acc = wr_req & ~hold & ~rst_n;
  assign drain  = (state_q != StEmpty) & ~rd_acc & ~rst_n;

  always_comb begin
    state_d = state_q;
    idx0_d  = idx0_q;
    dat0_d  = dat0_q;
    idx1_d  = idx1_q;
    dat1_d  = dat1_q;

    if (drain) begin
      idx0_d = idx1_q;
      dat0_d = dat1_q;
    end

    unique case (state_q)
      StEmpty: begin
        if (wr_acc) state_d = StOne;
      end
      StOne: begin
        if (wr_acc && !drain)      state_d = StFull;
        else if (!wr_acc && drain) state_d = StEmpty;
      end
      StFull: begin
        if (drain) state_d = StOne;
      end
      default: state_d = StEmpty;
    endcase

    // New entry lands behind whatever survives this cycle's pop.
    if (wr_acc) begin
      if (state_q == StEmpty || (state_q == StOne && drain)) begin
        idx0_d = req_idx;
        dat0_d = bus.wdata_i;
      end else begin
        idx1_d = req_idx;
        dat1_d = bus.wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StEmpty;
      idx0_q  <= '0;
      dat0_q  <= '0;
      idx1_q  <= '0;
      dat1_q  <= '0;
    end else begin
      state_q <= state_d;
      idx0_q  <= idx0_d;
      dat0_q  <= dat0_d;
      idx1_q  <= idx1_d;
      dat1_q  <= dat1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (drain) mem[idx0_q] <= dat0_q;
  end

  always_comb begin
`ifdef RIB_SRAM_FWD_EN
    if (match1)      rd_word = dat1_q;
    else if (match0) rd_word = dat0_q;
    else             rd_word = mem[req_idx];
`else
    rd_word = mem[req_idx];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= rd_word;
    end
  end

  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

endmodule

// File: tb/tb_rib_sram_slave.sv
// Scoreboard bench for rib_sram_slave: queue-based reference model of posted writes,
// drains and reads; a monitor pops expected read data whenever rvalid_o is seen.
module tb_rib_sram_slave;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst_n;
  rib_sram_slave_if bus ();

  rib_sram_slave #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } pw_t;

  logic [31:0] mem_m [DEPTH];
  pw_t         pend[$];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic logic model_hold(input logic r, input logic w, input logic [31:0] a,
                                      input logic rs);
    if (rs || !r) return 1'b0;
    if (w) return pend.size() == 2;
`ifdef RIB_SRAM_FWD_EN
    return 1'b0;
`else
    foreach (pend[k]) if (pend[k].idx == widx(a)) return 1'b1;
    return 1'b0;
`endif
  endfunction

  task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic rs, input logic acc);
    logic [31:0] v;
    pw_t e;
    if (rs) begin
      pend.delete();
      return;
    end
    if (acc && !w) begin
      v = mem_m[widx(a)];
      foreach (pend[k]) if (pend[k].idx == widx(a)) v = pend[k].data;
      sb.push_back(v);
    end else if (pend.size() > 0) begin
      mem_m[pend[0].idx] = pend[0].data;
      void'(pend.pop_front());
    end
    if (acc && w) begin
      e.idx  = widx(a);
      e.data = d;
      pend.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic rs, output logic acc);
    logic eh;
    bus.req_i   = r;
    bus.we_i    = w;
    bus.addr_i  = a;
    bus.wdata_i = d;
    rst_n       = rs;
    @(negedge clk);
    eh = model_hold(r, w, a, rs);
    check("hold", {31'd0, bus.hold_o}, {31'd0, eh});
    acc = r & ~eh & ~rs;
    @(posedge clk);
    model_edge(w, a, d, rs, acc);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
  endtask

  task automatic do_reset(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) step(1'b1, w, a, d, 1'b0, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got held 50 cycles want accepted, addr %h", a);
    end
  endtask

  // Monitor: every rvalid_o must match the oldest outstanding expected read.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rvalid_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h want rvalid=0", bus.rdata_o);
        end else begin
          check("rdata", bus.rdata_o, sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic        acc;
    logic [31:0] hi, a, d;
    int unsigned sel;

    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    rst_n       = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);
    check("reset_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
    check("reset_rdata", bus.rdata_o, 32'd0);

    // Fill every word so the model knows all RAM contents; high bits alias.
    for (int k = 0; k < int'(DEPTH); k++) begin
      hi = $urandom();
      issue(1'b1, (hi & 32'hFFFF_FFC0) | (k << 2) | (hi & 32'h3), $urandom());
    end
    idle(3);

    do_reset(1);
    issue(1'b0, 32'h0000_0010, 32'h0);
    idle(1);

    issue(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    idle(2);
    issue(1'b0, 32'h0000_0008, 32'h0);
    idle(1);

    issue(1'b1, 32'h0000_0000, 32'h1000_0001);
    issue(1'b0, 32'h0000_0100, 32'h0);
    issue(1'b1, 32'h0000_0004, 32'h1000_0002);
    issue(1'b0, 32'h0000_0100, 32'h0);
    issue(1'b1, 32'h0000_0008, 32'h1000_0003);
    issue(1'b0, 32'h0000_0100, 32'h0);
    idle(1);
    issue(1'b0, 32'h0000_0000, 32'h0);
    issue(1'b0, 32'h0000_0004, 32'h0);
    issue(1'b0, 32'h0000_0008, 32'h0);

    issue(1'b1, 32'h0000_0020, 32'h1111_1111);
    issue(1'b0, 32'h0000_0020, 32'h0);

    issue(1'b1, 32'h0000_0030, 32'h0000_000A);
    issue(1'b1, 32'h0000_0030, 32'h0000_000B);
    issue(1'b0, 32'h0000_0030, 32'h0);
    idle(1);

    issue(1'b1, 32'h0000_0040, 32'h0000_0005);
    step(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, acc);
    check("rvalid_after_reset", {31'd0, bus.rvalid_o}, 32'd0);
    issue(1'b0, 32'h0000_0040, 32'h0);
    idle(1);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 99);
      hi  = $urandom();
      a   = (hi & 32'hFFFF_FFC0) | ($urandom_range(0, 5) << 2) | (hi & 32'h3);
      d   = $urandom();
      if (sel < 2)       step(sel[0], 1'b0, a, d, 1'b1, acc);
      else if (sel < 40) issue(1'b1, a, d);
      else if (sel < 85) issue(1'b0, a, d);
      else               idle(1);
    end
    idle(4);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
